// File: rtl/matmul_pkg.sv
// Shared types for the result side of the systolic matmul array.
package matmul_pkg;

    typedef logic [31:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STREAM,
        ST_WAIT_CLR
    } state_t;

    function automatic int calc_mn(input int m, input int n);
        return m * n;
    endfunction

endpackage

// File: rtl/matmul_result_streamer_if.sv
// Element stream from the result streamer to the downstream writer.
interface matmul_result_streamer_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_eol;
    logic              out_last;

    modport master (output out_valid, out_data, out_eol, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_eol, out_last, output out_ready);
endinterface

// File: rtl/matmul_idx_gen.sv
// Row/col walker over C; exposes the index and flags for the element after the next advance.
module matmul_idx_gen #(
    parameter int M         = 16,
    parameter int N         = 16,
    parameter int COL_MAJOR = 0,
    parameter int IDX_W     = $clog2(M * N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [IDX_W-1:0] nxt_idx,
    output logic             cur_eol,
    output logic             cur_last,
    output logic             nxt_eol,
    output logic             nxt_last
);
    localparam int RW = $clog2(M);
    localparam int CW = $clog2(N);
    localparam logic [RW-1:0] R_MAX = RW'(M - 1);
    localparam logic [CW-1:0] C_MAX = CW'(N - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (COL_MAJOR != 0) begin
            if (row_q == R_MAX) begin
                row_d = '0;
                col_d = col_q + 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end else begin
            if (col_q == C_MAX) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        nxt_idx  = IDX_W'(row_d) * IDX_W'(N) + IDX_W'(col_d);
        cur_eol  = (COL_MAJOR != 0) ? (row_q == R_MAX) : (col_q == C_MAX);
        nxt_eol  = (COL_MAJOR != 0) ? (row_d == R_MAX) : (col_d == C_MAX);
        cur_last = (row_q == R_MAX) && (col_q == C_MAX);
        nxt_last = (row_d == R_MAX) && (col_d == C_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr) begin
            row_q <= '0;
            col_q <= '0;
        end else if (adv) begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/matmul_result_streamer.sv
// Launches the systolic array, snapshots C on done, then streams it one element per beat.
module matmul_result_streamer
    import matmul_pkg::*;
#(
    parameter int M         = 16,
    parameter int N         = 16,
    parameter int DATA_W    = $bits(acc_t),
    parameter int COL_MAJOR = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    output logic                          busy,
    output logic                          mm_start,
    input  logic                          mm_done,
    input  logic [M*N-1:0][DATA_W-1:0]    c_in,
    matmul_result_streamer_if.master      st
);
    localparam int MN    = calc_mn(M, N);
    localparam int IDX_W = $clog2(MN);

    state_t state_q, state_d;

    logic [MN-1:0][DATA_W-1:0] mem_q;
    logic                      valid_q, eol_q, last_q;
    logic [DATA_W-1:0]         data_q;
    logic [IDX_W-1:0]          nxt_idx;
    logic                      cur_eol, cur_last, nxt_eol, nxt_last;
    logic                      beat, capture, adv, clr;

    assign beat    = valid_q && st.out_ready;
    assign capture = (state_q == ST_RUN) && mm_done;
    assign adv     = (state_q == ST_STREAM) && beat && !last_q;
    assign clr     = (state_q != ST_STREAM) || (beat && last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A done still high after the final beat means the array has not yet
    // seen start low; park in WAIT_CLR until it returns to IDLE.
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != ST_IDLE);
        mm_start = (state_q == ST_RUN);
        unique case (state_q)
            ST_IDLE:     if (req) state_d = ST_RUN;
            ST_RUN:      if (mm_done) state_d = ST_STREAM;
            ST_STREAM:   if (beat && last_q) state_d = mm_done ? ST_WAIT_CLR : ST_IDLE;
            ST_WAIT_CLR: if (!mm_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (capture) mem_q <= c_in;
    end

    matmul_idx_gen #(
        .M(M), .N(N), .COL_MAJOR(COL_MAJOR), .IDX_W(IDX_W)
    ) u_idx (
        .clk, .rst_n, .clr, .adv,
        .nxt_idx, .cur_eol, .cur_last, .nxt_eol, .nxt_last
    );

    // Element 0 comes straight from c_in since the buffer fills on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            data_q  <= c_in[0];
            eol_q   <= cur_eol;
            last_q  <= cur_last;
        end else if (beat) begin
            if (last_q) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                eol_q   <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                data_q  <= mem_q[nxt_idx];
                eol_q   <= nxt_eol;
                last_q  <= nxt_last;
            end
        end
    end

    assign st.out_valid = valid_q;
    assign st.out_data  = data_q;
    assign st.out_eol   = eol_q;
    assign st.out_last  = last_q;
endmodule

// File: tb/tb_matmul_result_streamer.sv
// Directed bench: row- and column-major 4x4 instances sharing clock, reset, done and C.
module tb_matmul_result_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, req_r, req_c, mm_done, rdy, sel;
    logic [15:0][31:0] c_in;
    logic             busy_r, busy_c, start_r, start_c;

    matmul_result_streamer_if #(.DATA_W(32)) if_r ();
    matmul_result_streamer_if #(.DATA_W(32)) if_c ();

    assign if_r.out_ready = rdy;
    assign if_c.out_ready = rdy;

    matmul_result_streamer #(.M(4), .N(4), .DATA_W(32), .COL_MAJOR(0)) dut_r (
        .clk(clk), .rst_n(rst_n), .req(req_r), .busy(busy_r), .mm_start(start_r),
        .mm_done(mm_done), .c_in(c_in), .st(if_r)
    );

    matmul_result_streamer #(.M(4), .N(4), .DATA_W(32), .COL_MAJOR(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .busy(busy_c), .mm_start(start_c),
        .mm_done(mm_done), .c_in(c_in), .st(if_c)
    );

    logic        obs_valid, obs_eol, obs_last, obs_busy, obs_start;
    logic [31:0] obs_data;
    assign obs_valid = sel ? if_c.out_valid : if_r.out_valid;
    assign obs_eol   = sel ? if_c.out_eol   : if_r.out_eol;
    assign obs_last  = sel ? if_c.out_last  : if_r.out_last;
    assign obs_data  = sel ? if_c.out_data  : if_r.out_data;
    assign obs_busy  = sel ? busy_c : busy_r;
    assign obs_start = sel ? start_c : start_r;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) c_in[i] = 32'(100 + i);
    endtask

    // Request a run, let the array report done 10 cycles after start, drop done once start falls.
    task automatic launch(input bit hold_req, input bit keep_done, input bit dead);
        int n = 0;
        if (sel) req_c = 1'b1; else req_r = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (obs_start) break;
        end
        check("start_lat", n, 1);
        check("busy_run", obs_busy, 1);
        if (!hold_req) begin
            req_r = 1'b0;
            req_c = 1'b0;
        end
        repeat (9) @(negedge clk);
        check("start_held", obs_start, 1);
        mm_done = 1'b1;
        @(negedge clk);
        check("start_fall", obs_start, 0);
        if (!keep_done) mm_done = 1'b0;
        if (dead) for (int i = 0; i < 16; i++) c_in[i] = 32'hDEAD;
    endtask

    // pat 0: ready always high; pat 1: ready 1,0,0,1 repeating.
    task automatic stream(input bit pat, input int nbeats);
        int k = 0, cyc = 0, ph = 0, idx;
        bit stalled = 1'b0;
        logic [31:0] hd;
        logic he, hl;
        while (k < nbeats && cyc < 200) begin
            rdy = (pat == 1'b0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
            ph++;
            if (stalled) begin
                check("stall_vld", obs_valid, 1);
                check("stall_data", obs_data, hd);
                check("stall_flags", {obs_eol, obs_last}, {he, hl});
            end
            if (pat == 1'b0 && !obs_valid) check("b2b_vld", obs_valid, 1);
            if (obs_valid) begin
                if (rdy) begin
                    idx = sel ? (k % 4) * 4 + k / 4 : k;
                    check("data", obs_data, 32'(100 + idx));
                    check("eol", obs_eol, (k % 4 == 3));
                    check("last", obs_last, (k == 15));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = obs_data;
                    he = obs_eol;
                    hl = obs_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (k < nbeats) check("stream_timeout", k, nbeats);
        rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_r = 1'b0; req_c = 1'b0; mm_done = 1'b0; rdy = 1'b1; sel = 1'b0;
        fill();
        #3;
        check("rst_busy", busy_r, 0);
        check("rst_start", start_r, 0);
        check("rst_valid", if_r.out_valid, 0);
        check("rst_data", if_r.out_data, 0);
        check("rst_flags", {if_r.out_eol, if_r.out_last}, 0);
        check("rst_c_valid", {if_c.out_valid, busy_c, start_c}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic row-major
        sel = 1'b0;
        launch(1'b0, 1'b0, 1'b0);
        stream(1'b0, 16);
        check("row_end_valid", obs_valid, 0);
        check("row_end_busy", obs_busy, 0);

        // column-major
        sel = 1'b1;
        launch(1'b0, 1'b0, 1'b0);
        stream(1'b0, 16);
        check("col_end_valid", obs_valid, 0);
        check("col_end_busy", obs_busy, 0);

        // backpressure with C overwritten after capture
        sel = 1'b0;
        launch(1'b0, 1'b0, 1'b1);
        stream(1'b1, 16);
        fill();
        check("bp_end_busy", obs_busy, 0);

        // done held high past the final beat
        launch(1'b0, 1'b1, 1'b0);
        stream(1'b0, 16);
        check("wc_busy", obs_busy, 1);
        check("wc_valid", obs_valid, 0);
        req_r = 1'b1;
        @(negedge clk);
        req_r = 1'b0;
        check("wc_req_ign", obs_start, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wc_hold_busy", obs_busy, 1);
        end
        check("wc_hold_start", obs_start, 0);
        mm_done = 1'b0;
        @(negedge clk);
        check("wc_exit_busy", obs_busy, 0);
        check("wc_exit_start", obs_start, 0);

        // reset after beat 6
        launch(1'b0, 1'b0, 1'b0);
        stream(1'b0, 6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", obs_valid, 0);
        check("mid_rst_start", obs_start, 0);
        check("mid_rst_busy", obs_busy, 0);
        check("mid_rst_last", obs_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(1'b0, 1'b0, 1'b0);
        stream(1'b0, 16);
        check("post_rst_busy", obs_busy, 0);

        // req held high across two runs
        launch(1'b1, 1'b0, 1'b0);
        stream(1'b0, 16);
        launch(1'b1, 1'b0, 1'b0);
        stream(1'b0, 16);
        req_r = 1'b0;
        @(negedge clk);
        check("hold_end_start", obs_start, 0);
        check("hold_end_busy", obs_busy, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
